// File: rtl/stack_engine_if.sv
// Command/status bundle between the calculator front end and the stack engine.
interface stack_engine_if;
    logic       OP_VALID;
    logic [2:0] OP;
    logic [7:0] DIN;
    logic       BUSY;
    logic [7:0] TOP;
    logic [6:0] SP;
    logic [1:0] ERR;

    modport master (
        output OP_VALID, OP, DIN,
        input  BUSY, TOP, SP, ERR
    );

    modport slave (
        input  OP_VALID, OP, DIN,
        output BUSY, TOP, SP, ERR
    );
endinterface

// File: rtl/stack_engine.sv
// 8-bit LIFO operand stack for the stack calculator.
// PUSH/DUP/CLEAR complete in one edge; POP/ADD/SUB read the second-from-top
// entry through a registered memory read and commit two edges later.
module stack_engine #(
    parameter int DEPTH = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    stack_engine_if.slave bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [6:0] LP_DEPTH = 7'(DEPTH);

    localparam logic [2:0] OP_PUSH  = 3'd0;
    localparam logic [2:0] OP_POP   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_DUP   = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC
    } state_t;

    state_t          r_state;
    logic [6:0]      r_sp;
    logic [7:0]      r_top;
    logic [1:0]      r_err;
    logic [2:0]      r_op;
    logic [AW-1:0]   r_raddr;
    logic [7:0]      r_rdata;
    logic [7:0]      r_mem [DEPTH];

    state_t          w_state_nxt;
    logic [6:0]      w_sp_nxt;
    logic [7:0]      w_top_nxt;
    logic [1:0]      w_err_nxt;
    logic [2:0]      w_op_nxt;
    logic [AW-1:0]   w_raddr_nxt;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [7:0]      w_wdata;
    logic [7:0]      w_res;
    logic [AW-1:0]   w_below_top;

    // Address of the second-from-top entry; forced to 0 when it does not exist
    // so the read never indexes past the array for non-power-of-two depths.
    assign w_below_top = (r_sp >= 7'd2) ? AW'(r_sp - 7'd2) : '0;

    // Arithmetic result: second-from-top op top, modulo 256.
    assign w_res = (r_op == OP_SUB) ? (r_rdata - r_top) : (r_rdata + r_top);

    // Next-state, command decode and memory write control.
    always_comb begin
        w_state_nxt = r_state;
        w_sp_nxt    = r_sp;
        w_top_nxt   = r_top;
        w_err_nxt   = r_err;
        w_op_nxt    = r_op;
        w_raddr_nxt = r_raddr;
        w_we        = 1'b0;
        w_waddr     = AW'(r_sp);
        w_wdata     = bus.DIN;

        case (r_state)
            S_IDLE: begin
                if (bus.OP_VALID) begin
                    case (bus.OP)
                        OP_PUSH: begin
                            if (r_sp == LP_DEPTH) begin
                                w_err_nxt = ERR_OVF;
                            end else begin
                                w_we      = 1'b1;
                                w_wdata   = bus.DIN;
                                w_top_nxt = bus.DIN;
                                w_sp_nxt  = r_sp + 7'd1;
                                w_err_nxt = ERR_NONE;
                            end
                        end
                        OP_POP: begin
                            if (r_sp == 7'd0) begin
                                w_err_nxt = ERR_UNF;
                            end else begin
                                w_op_nxt    = bus.OP;
                                w_raddr_nxt = w_below_top;
                                w_state_nxt = S_READ;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (r_sp < 7'd2) begin
                                w_err_nxt = ERR_UNF;
                            end else begin
                                w_op_nxt    = bus.OP;
                                w_raddr_nxt = w_below_top;
                                w_state_nxt = S_READ;
                            end
                        end
                        OP_DUP: begin
                            if (r_sp == 7'd0) begin
                                w_err_nxt = ERR_UNF;
                            end else if (r_sp == LP_DEPTH) begin
                                w_err_nxt = ERR_OVF;
                            end else begin
                                w_we      = 1'b1;
                                w_wdata   = r_top;
                                w_sp_nxt  = r_sp + 7'd1;
                                w_err_nxt = ERR_NONE;
                            end
                        end
                        OP_CLEAR: begin
                            w_sp_nxt  = 7'd0;
                            w_top_nxt = 8'h00;
                            w_err_nxt = ERR_NONE;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_READ: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_IDLE;
                w_sp_nxt    = r_sp - 7'd1;
                w_err_nxt   = ERR_NONE;
                if (r_op == OP_POP) begin
                    w_top_nxt = (r_sp == 7'd1) ? 8'h00 : r_rdata;
                end else begin
                    w_we      = 1'b1;
                    w_waddr   = w_below_top;
                    w_wdata   = w_res;
                    w_top_nxt = w_res;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and architectural registers; reset aborts any in-flight op.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_sp    <= 7'd0;
            r_top   <= 8'h00;
            r_err   <= ERR_NONE;
            r_op    <= OP_PUSH;
            r_raddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sp    <= w_sp_nxt;
            r_top   <= w_top_nxt;
            r_err   <= w_err_nxt;
            r_op    <= w_op_nxt;
            r_raddr <= w_raddr_nxt;
        end
    end

    // Stack storage with registered read; writes never occur while a read is pending.
    always_ff @(posedge CLK) begin
        if (w_we && !RESET) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rdata <= r_mem[r_raddr];
    end

    assign bus.BUSY = (r_state != S_IDLE);
    assign bus.TOP  = r_top;
    assign bus.SP   = r_sp;
    assign bus.ERR  = r_err;

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine against a queue-based LIFO model.
module tb_stack_engine;

    localparam int DEPTH = 16;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    stack_engine_if bus ();

    stack_engine #(.DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: the stack as a queue, last element is the top.
    byte unsigned q[$];
    logic [1:0]   m_err = 2'b00;

    function automatic logic [7:0] m_top();
        if (q.size() == 0) return 8'h00;
        return q[q.size()-1];
    endfunction

    task automatic model(input logic [2:0] op, input logic [7:0] d, output int exp_busy);
        byte unsigned a, b;
        exp_busy = 0;
        case (op)
            3'd0: if (q.size() == DEPTH) m_err = 2'b01;
                  else begin q.push_back(d); m_err = 2'b00; end
            3'd1: if (q.size() == 0) m_err = 2'b10;
                  else begin void'(q.pop_back()); m_err = 2'b00; exp_busy = 2; end
            3'd2, 3'd3:
                  if (q.size() < 2) m_err = 2'b10;
                  else begin
                      a = q.pop_back();
                      b = q.pop_back();
                      q.push_back((op == 3'd2) ? 8'(b + a) : 8'(b - a));
                      m_err = 2'b00;
                      exp_busy = 2;
                  end
            3'd4: if (q.size() == 0) m_err = 2'b10;
                  else if (q.size() == DEPTH) m_err = 2'b01;
                  else begin q.push_back(q[q.size()-1]); m_err = 2'b00; end
            3'd5: begin q.delete(); m_err = 2'b00; end
            default: ;
        endcase
    endtask

    // Drive one strobe, then count BUSY cycles (bounded) until the engine is idle.
    task automatic issue(input logic [2:0] op, input logic [7:0] d, output int busy_cycles);
        @(negedge CLK);
        bus.OP_VALID = 1'b1;
        bus.OP       = op;
        bus.DIN      = d;
        @(posedge CLK);
        #1;
        bus.OP_VALID = 1'b0;
        bus.DIN      = 8'($urandom);
        busy_cycles  = 0;
        while (bus.BUSY === 1'b1 && busy_cycles < 10) begin
            @(posedge CLK);
            #1;
            busy_cycles++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.OP_VALID = 1'b0;
        bus.OP = 3'd0;
        bus.DIN = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({bus.TOP, bus.SP, bus.ERR, bus.BUSY} !== 18'h0) begin
            errors++;
            $display("FAIL reset: top=%h sp=%0d err=%b busy=%b, want all zero",
                     bus.TOP, bus.SP, bus.ERR, bus.BUSY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        q.delete();
        m_err = 2'b00;
    endtask

    // Runs a table of commands, comparing the full status after each one.
    task automatic run_table(input string tag, input logic [2:0] ops[], input logic [7:0] dins[]);
        int bc, eb;
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i], dins[i], bc);
            model(ops[i], dins[i], eb);
            checks++;
            if ({bus.TOP, bus.SP, bus.ERR, bus.BUSY} !== {m_top(), 7'(q.size()), m_err, 1'b0} || bc != eb) begin
                errors++;
                $display("FAIL %s[%0d] op=%0d: top=%h sp=%0d err=%b busy=%b cyc=%0d, want top=%h sp=%0d err=%b cyc=%0d",
                         tag, i, ops[i], bus.TOP, bus.SP, bus.ERR, bus.BUSY, bc,
                         m_top(), q.size(), m_err, eb);
            end
        end
    endtask

    task automatic test_push_add();
        logic [2:0] ops[]  = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd6};
        logic [7:0] dins[] = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h99};
        run_table("push_add", ops, dins);
        checks++;
        if (bus.TOP !== 8'h46 || bus.SP !== 7'd1 || bus.ERR !== 2'b10) begin
            errors++;
            $display("FAIL add_sub_result: top=%h sp=%0d err=%b, want top=46 sp=1 err=10",
                     bus.TOP, bus.SP, bus.ERR);
        end
    endtask

    task automatic test_sub_wrap();
        logic [2:0] ops[]  = '{3'd5, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd2};
        logic [7:0] dins[] = '{8'h00, 8'h05, 8'h07, 8'h00, 8'hFF, 8'h02, 8'h00};
        run_table("sub_wrap", ops, dins);
    endtask

    task automatic test_overflow();
        logic [2:0] ops[]  = new[DEPTH + 4];
        logic [7:0] dins[] = new[DEPTH + 4];
        ops[0] = 3'd5; dins[0] = 8'h00;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            ops[i]  = 3'd0;
            dins[i] = 8'($urandom);
        end
        ops[DEPTH+2] = 3'd4; dins[DEPTH+2] = 8'h00;
        ops[DEPTH+3] = 3'd1; dins[DEPTH+3] = 8'h00;
        run_table("overflow", ops, dins);
        checks++;
        if (bus.SP !== 7'(DEPTH - 1) || bus.TOP !== dins[DEPTH - 1]) begin
            errors++;
            $display("FAIL full_pop: sp=%0d top=%h, want sp=%0d top=%h",
                     bus.SP, bus.TOP, DEPTH - 1, dins[DEPTH - 1]);
        end
    endtask

    task automatic test_pop_empty();
        logic [2:0] ops[]  = '{3'd5, 3'd0, 3'd1, 3'd1, 3'd4, 3'd2, 3'd7};
        logic [7:0] dins[] = '{8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11};
        run_table("pop_empty", ops, dins);
    endtask

    // A strobe and DIN changes arriving while BUSY must not disturb the ADD.
    task automatic test_busy_drop();
        int  eb, bc;
        logic busy_seen;
        issue(3'd0, 8'h21, bc); model(3'd0, 8'h21, eb);
        issue(3'd0, 8'h0F, bc); model(3'd0, 8'h0F, eb);
        @(negedge CLK);
        bus.OP_VALID = 1'b1;
        bus.OP       = 3'd2;
        bus.DIN      = 8'h00;
        @(negedge CLK);
        busy_seen    = bus.BUSY;
        bus.OP       = 3'd0;
        bus.DIN      = 8'hAA;
        @(negedge CLK);
        busy_seen    = busy_seen & bus.BUSY;
        bus.DIN      = 8'h55;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        model(3'd2, 8'h00, eb);
        checks++;
        if ({bus.TOP, bus.SP, bus.ERR, bus.BUSY} !== {m_top(), 7'(q.size()), m_err, 1'b0} || busy_seen !== 1'b1) begin
            errors++;
            $display("FAIL busy_drop: top=%h sp=%0d err=%b busy_seen=%b, want top=%h sp=%0d err=%b busy_seen=1",
                     bus.TOP, bus.SP, bus.ERR, busy_seen, m_top(), q.size(), m_err);
        end
    endtask

    task automatic test_reset_exec();
        int eb, bc;
        issue(3'd0, 8'h44, bc); model(3'd0, 8'h44, eb);
        issue(3'd0, 8'h55, bc); model(3'd0, 8'h55, eb);
        @(negedge CLK);
        bus.OP_VALID = 1'b1;
        bus.OP       = 3'd2;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.TOP, bus.SP, bus.ERR, bus.BUSY} !== 18'h0) begin
            errors++;
            $display("FAIL reset_exec: top=%h sp=%0d err=%b busy=%b, want all zero",
                     bus.TOP, bus.SP, bus.ERR, bus.BUSY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        q.delete();
        m_err = 2'b00;
        for (int i = 0; i < 5; i++) begin
            issue(3'd0, 8'(i * 7 + 1), bc);
            model(3'd0, 8'(i * 7 + 1), eb);
        end
        issue(3'd5, 8'h00, bc); model(3'd5, 8'h00, eb);
        checks++;
        if ({bus.TOP, bus.SP, bus.ERR} !== {m_top(), 7'(q.size()), m_err} || bus.SP !== 7'd0) begin
            errors++;
            $display("FAIL clear5: top=%h sp=%0d err=%b, want top=00 sp=0 err=00",
                     bus.TOP, bus.SP, bus.ERR);
        end
    endtask

    task automatic test_random();
        int eb, bc, r;
        logic [2:0] op;
        logic [7:0] d;
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 11);
            op = (r < 4) ? 3'd0 : ((r - 3 > 7) ? 3'd6 : 3'(r - 3));
            d  = 8'($urandom);
            issue(op, d, bc);
            model(op, d, eb);
            checks++;
            if ({bus.TOP, bus.SP, bus.ERR, bus.BUSY} !== {m_top(), 7'(q.size()), m_err, 1'b0} || bc != eb) begin
                errors++;
                $display("FAIL random[%0d] op=%0d din=%h: top=%h sp=%0d err=%b cyc=%0d, want top=%h sp=%0d err=%b cyc=%0d",
                         n, op, d, bus.TOP, bus.SP, bus.ERR, bc, m_top(), q.size(), m_err, eb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_add();
        test_sub_wrap();
        test_overflow();
        test_pop_empty();
        test_busy_drop();
        test_reset_exec();
        test_random();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
